c_buffer: RTL
=============

C_BUFFER -- requirements
Module: c_buffer

Interface
REQ-001 Parameter N, default 8: systolic array dimension (rows = columns = N).
REQ-002 Parameter DATA_W, default 32: per-PE accumulator/result width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 output_write  input  1  drain-cycle strobe from controller; one skewed result slice per asserted cycle.
REQ-006 c_in  input  N*DATA_W  bottom-of-column array outputs; column j occupies bits [j*DATA_W +: DATA_W].
REQ-007 read_valid  output  1  complete matrix held and not fully read; drives controller read_valid.
REQ-008 c_valid  output  1  row-stream valid toward external reader.
REQ-009 c_ready  input  1  row-stream ready from external reader.
REQ-010 c_data  output  N*DATA_W  current result row; column j at bits [j*DATA_W +: DATA_W].
REQ-011 c_row  output  3  index of the row on c_data (log2 N bits).
REQ-012 c_last  output  1  high with c_valid when c_row == N-1.
REQ-013 overflow  output  1  sticky error; output_write arrived while matrix still held.

Function
REQ-014 States SHALL be EMPTY, FILL and FULL; reset state EMPTY.
REQ-015 EMPTY: output_write=1 -> perform drain write with drain index k=0, go FILL, k becomes 1.
REQ-016 Drain write at index k SHALL store c_in column j into mem[k-j][j] for every j with 0 <= k-j <= N-1; all other cells unchanged.
REQ-017 FILL: each output_write=1 cycle performs drain write at current k and increments k; output_write=0 holds k and memory (stall tolerated indefinitely).
REQ-018 FILL: drain write at k == 2N-2 (14 for N=8) SHALL be the last; next state FULL, k cleared to 0.
REQ-019 FULL: read_valid=1 and c_valid=1 starting the cycle after the last drain write (1-cycle latency).
REQ-020 FULL: c_data = mem[c_row] combinationally; c_row starts at 0.
REQ-021 Handshake: c_valid && c_ready SHALL advance c_row by 1; c_data/c_row SHALL stay stable while c_valid && !c_ready.
REQ-022 Handshake on c_row == N-1 SHALL return to EMPTY; read_valid and c_valid low the next cycle, c_row cleared to 0.
REQ-023 output_write in FULL SHALL be ignored (no memory write, no state change) and SHALL set overflow.
REQ-024 overflow SHALL stay set until rst.
REQ-025 In EMPTY and FILL: c_valid=0, read_valid=0, c_last=0, c_data driven all-zero.
REQ-026 k SHALL be ceil(log2(2N-1)) bits (4 for N=8); no wrap occurs since FILL exits at 2N-2.

Reset
REQ-027 rst SHALL asynchronously force state EMPTY, k=0, c_row=0, overflow=0, and all outputs low/zero, including mid-FILL and mid-read.
REQ-028 Result memory contents SHALL NOT require reset; outputs are masked until a full fill completes.

Structure
REQ-029 N, DATA_W and the state enum type SHALL live in shared package sa_pkg, also used by the controller.
REQ-030 One sub-module c_skew_decode SHALL map drain index k to per-column write enables and per-column row indices (purely combinational).
REQ-031 Memory SHALL be N x N registers of DATA_W bits, no RAM macro.

Verification
REQ-032 Drain 15 cycles with column j at cycle k carrying value 100*(k-j)+j -> rows 0..7 read out with c_data col j == 100*row+j, c_last only on row 7.
REQ-033 Same drain with output_write low for 3 cycles after k=5 -> identical readout, read_valid rises exactly 1 cycle after 15th strobe.
REQ-034 FULL with c_ready held low 10 cycles then pulsed every other cycle -> c_row/c_data stable while stalled, 8 transfers total, then EMPTY.
REQ-035 output_write asserted during FULL -> overflow=1, memory and readout unchanged, overflow persists after return to EMPTY.
REQ-036 rst asserted after drain index 7, then a full 15-cycle drain -> read_valid low until new fill completes, readout matches new data only.
REQ-037 Back-to-back: second drain begins the cycle after the row-7 handshake -> accepted as k=0, no overflow, correct second matrix.

Source files
------------

// File: rtl/sa_pkg.sv
// sa_pkg: shared systolic-array sizing and result-buffer state type
package sa_pkg;
   localparam int SA_N      = 8;
   localparam int SA_DATA_W = 32;
   typedef enum logic [1:0] {EMPTY, FILL, FULL} buf_state_e;
   // Drain index width: enough to count 0..2n-2
   function automatic int k_bits(input int n);
      return $clog2(2 * n - 1);
   endfunction
endpackage

// File: rtl/c_skew_decode.sv
// c_skew_decode: maps drain index k to per-column write enables and target rows
module c_skew_decode #(
   parameter int N  = 8,
   parameter int KW = 4,
   parameter int RW = 3
) (
   input  logic [KW-1:0]         k,
   output logic [N-1:0]          we,
   output logic [N-1:0][RW-1:0]  row
);
   // Column j carries row k-j of the result; valid only while 0 <= k-j < N
   always_comb begin
      for (int j = 0; j < N; j++) begin
         we[j]  = (int'(k) >= j) && (int'(k) - j < N);
         row[j] = RW'(int'(k) - j);
      end
   end
endmodule

// File: rtl/c_buffer.sv
// c_buffer: deskews systolic drain slices into an NxN matrix and streams it out by row
module c_buffer
   import sa_pkg::*;
#(
   parameter int N      = SA_N,
   parameter int DATA_W = SA_DATA_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    output_write,
   input  logic [N*DATA_W-1:0]     c_in,
   output logic                    read_valid,
   output logic                    c_valid,
   input  logic                    c_ready,
   output logic [N*DATA_W-1:0]     c_data,
   output logic [$clog2(N)-1:0]    c_row,
   output logic                    c_last,
   output logic                    overflow
);
   localparam int KW = k_bits(N);
   localparam int RW = $clog2(N);
   localparam logic [KW-1:0] LAST_K = KW'(2 * N - 2);
   localparam logic [RW-1:0] LAST_R = RW'(N - 1);
   buf_state_e state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [RW-1:0] row_q, row_d;
   logic ovf_q, ovf_d;
   logic wr;
   logic [N-1:0] we;
   logic [N-1:0][RW-1:0] wrow;
   logic [N-1:0][DATA_W-1:0] mem_q [N];
   logic [N-1:0][DATA_W-1:0] mem_d [N];
   c_skew_decode #(.N(N), .KW(KW), .RW(RW)) u_dec (
      .k   (k_q),
      .we  (we),
      .row (wrow)
   );
   // Control state; memory is deliberately left out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         k_q     <= '0;
         row_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         row_q   <= row_d;
         ovf_q   <= ovf_d;
      end
   end
   // Next state: drain writes while not FULL, row handshakes while FULL
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      row_d   = row_q;
      ovf_d   = ovf_q;
      wr      = 1'b0;
      case (state_q)
         EMPTY, FILL: begin
            if (output_write) begin
               wr      = 1'b1;
               k_d     = (k_q == LAST_K) ? '0 : k_q + KW'(1);
               state_d = (k_q == LAST_K) ? FULL : FILL;
            end
         end
         FULL: begin
            ovf_d = ovf_q | output_write;
            if (c_ready) begin
               row_d   = (row_q == LAST_R) ? '0 : row_q + RW'(1);
               state_d = (row_q == LAST_R) ? EMPTY : FULL;
            end
         end
         default: state_d = EMPTY;
      endcase
   end
   // Result matrix: scatter the current skewed slice into its diagonal cells
   always_comb begin
      mem_d = mem_q;
      for (int j = 0; j < N; j++)
         if (wr && we[j]) mem_d[wrow[j]][j] = c_in[j*DATA_W +: DATA_W];
   end
   // Matrix registers
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end
   // Outputs are masked until a complete matrix is held
   always_comb begin
      read_valid = state_q == FULL;
      c_valid    = state_q == FULL;
      c_last     = (state_q == FULL) && (row_q == LAST_R);
      c_data     = (state_q == FULL) ? mem_q[row_q] : '0;
      c_row      = row_q;
      overflow   = ovf_q;
   end
endmodule
